// File: rtl/coin_pkg.sv
// Shared coin definitions for the coin accumulator and the downstream vending FSM:
// coin_type encodings, accumulator state enum, bus width and coin value decode.
package coin_pkg;

  localparam int CREDIT_W = 5;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_BAD  = 2'b11
  } coin_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_OFFER   = 2'b10,
    ST_REFUND  = 2'b11
  } coin_state_e;

  // Face value of a coin; invalid encodings are worth 0 so they can never be accepted.
  function automatic logic [3:0] coin_value(input logic [1:0] coin_type);
    logic [3:0] value;
    case (coin_type)
      COIN_5:  value = 4'd5;
      COIN_10: value = 4'd10;
      default: value = 4'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/coin_accumulator.sv
// Coin accumulator: collects coins into credit, offers settled credit on a valid/ack
// handshake, rejects over-limit coins and refunds on cancel. COIN_AUTO_REFUND_EN adds an OFFER watchdog.
module coin_accumulator #(
  parameter int CREDIT_W      = coin_pkg::CREDIT_W,
  parameter int MAX_CREDIT    = 15,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  input  logic                vend_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                credit_valid,
  output logic                coin_reject,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund_amt
);
  import coin_pkg::*;

  // Handshake: credit_valid stays high with credit stable until vend_ack is seen;
  // the credit is consumed and cleared on the edge where both are high.

  localparam int TIMER_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0]  SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [CREDIT_W:0]   MAX_EXT     = (CREDIT_W + 1)'(MAX_CREDIT);

  coin_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                credit_valid_q, credit_valid_d;
  logic                coin_reject_q, coin_reject_d;
  logic                refund_valid_q, refund_valid_d;
  logic [CREDIT_W-1:0] refund_amt_q, refund_amt_d;

  logic [CREDIT_W:0]   sum;
  logic                coin_ok;
  logic                hits_max;
  logic                wd_expired;

`ifdef COIN_AUTO_REFUND_EN
  localparam int WD_CYCLES = 16 * SETTLE_CYCLES;
  localparam int WD_W      = $clog2(WD_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Counts cycles spent in OFFER; held at zero everywhere else.
  always_comb begin
    wd_d       = (state_q == ST_OFFER) ? wd_q + 1'b1 : '0;
    wd_expired = (state_q == ST_OFFER) && (wd_q == WD_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    sum      = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(coin_type));
    coin_ok  = coin_valid && (coin_value(coin_type) != 4'd0) && (sum <= MAX_EXT);
    hits_max = (sum == MAX_EXT);
  end

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    timer_d        = timer_q;
    credit_valid_d = 1'b0;
    coin_reject_d  = 1'b0;
    refund_valid_d = 1'b0;
    refund_amt_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (coin_ok) begin
          credit_d = sum[CREDIT_W-1:0];
          timer_d  = '0;
          if (hits_max) begin
            state_d        = ST_OFFER;
            credit_valid_d = 1'b1;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          coin_reject_d = coin_valid;
        end
      end

      ST_COLLECT: begin
        // Cancel beats a same-cycle coin, so the refund never includes that coin.
        if (cancel) begin
          state_d        = ST_REFUND;
          refund_valid_d = 1'b1;
          refund_amt_d   = credit_q;
          coin_reject_d  = coin_valid;
          timer_d        = '0;
        end else if (coin_ok) begin
          credit_d = sum[CREDIT_W-1:0];
          timer_d  = '0;
          if (hits_max) begin
            state_d        = ST_OFFER;
            credit_valid_d = 1'b1;
          end
        end else begin
          coin_reject_d = coin_valid;
          if (timer_q == SETTLE_LAST) begin
            state_d        = ST_OFFER;
            credit_valid_d = 1'b1;
            timer_d        = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end

      ST_OFFER: begin
        coin_reject_d = coin_valid;
        if (vend_ack) begin
          state_d  = ST_IDLE;
          credit_d = '0;
        end else if (cancel || wd_expired) begin
          state_d        = ST_REFUND;
          refund_valid_d = 1'b1;
          refund_amt_d   = credit_q;
        end else begin
          credit_valid_d = 1'b1;
        end
      end

      ST_REFUND: begin
        coin_reject_d = coin_valid;
        credit_d      = '0;
        state_d       = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
        timer_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      timer_q        <= '0;
      credit_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      refund_valid_q <= 1'b0;
      refund_amt_q   <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      timer_q        <= timer_d;
      credit_valid_q <= credit_valid_d;
      coin_reject_q  <= coin_reject_d;
      refund_valid_q <= refund_valid_d;
      refund_amt_q   <= refund_amt_d;
    end
  end

  assign credit       = credit_q;
  assign credit_valid = credit_valid_q;
  assign coin_reject  = coin_reject_q;
  assign refund_valid = refund_valid_q;
  assign refund_amt   = refund_amt_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Self-checking bench for coin_accumulator: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the credit rules.
module tb_coin_accumulator;

  localparam int W   = 5;
  localparam int MAX = 15;
  localparam int S   = 8;
`ifdef COIN_AUTO_REFUND_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         coin_valid;
  logic [1:0]   coin_type;
  logic         cancel;
  logic         vend_ack;
  logic [W-1:0] credit;
  logic         credit_valid;
  logic         coin_reject;
  logic         refund_valid;
  logic [W-1:0] refund_amt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state: expected outputs plus two counters.
  int m_credit, m_refund_amt, m_quiet, m_offer_age;
  bit m_valid, m_reject, m_refund;

  coin_accumulator #(.CREDIT_W(W), .MAX_CREDIT(MAX), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
    .cancel(cancel), .vend_ack(vend_ack), .credit(credit), .credit_valid(credit_valid),
    .coin_reject(coin_reject), .refund_valid(refund_valid), .refund_amt(refund_amt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_credit = 0; m_refund_amt = 0; m_quiet = 0; m_offer_age = 0;
    m_valid = 0; m_reject = 0; m_refund = 0;
  endtask

  // One clock edge of the credit rules, applied to the inputs seen at that edge.
  task automatic model_edge(input bit cv, input bit [1:0] ct, input bit cn, input bit ack);
    int v, n_credit, n_amt;
    bit n_valid, n_reject, n_refund;
    v = (ct == 2'b01) ? 5 : (ct == 2'b10) ? 10 : 0;
    n_credit = m_credit; n_amt = 0; n_valid = 0; n_reject = 0; n_refund = 0;
    if (m_refund) begin
      n_credit = 0;
      n_reject = cv;
    end else if (m_valid) begin
      n_reject = cv;
      if (ack) n_credit = 0;
      else if (cn || (AUTO && m_offer_age == 16 * S - 1)) begin
        n_refund = 1; n_amt = m_credit;
      end else begin
        n_valid = 1; m_offer_age++;
      end
    end else if (m_credit > 0 && cn) begin
      n_refund = 1; n_amt = m_credit; n_reject = cv;
    end else if (cv && v > 0 && m_credit + v <= MAX) begin
      n_credit = m_credit + v;
      m_quiet = 0;
      if (n_credit == MAX) begin n_valid = 1; m_offer_age = 0; end
    end else begin
      n_reject = cv;
      if (m_credit > 0) begin
        if (m_quiet == S - 1) begin n_valid = 1; m_offer_age = 0; end
        else m_quiet++;
      end
    end
    m_credit = n_credit; m_refund_amt = n_amt; m_valid = n_valid;
    m_reject = n_reject; m_refund = n_refund;
  endtask

  task automatic step(input bit cv, input bit [1:0] ct, input bit cn, input bit ack);
    coin_valid = cv; coin_type = ct; cancel = cn; vend_ack = ack;
    @(posedge clk);
    model_edge(cv, ct, cn, ack);
    #1;
    coin_valid = 0; coin_type = 2'b00; cancel = 0; vend_ack = 0;
  endtask

  task automatic idle();
    step(0, 2'b00, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1; coin_valid = 0; coin_type = 2'b00; cancel = 0; vend_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (credit !== 5'd0) begin n_fail++; $display("FAIL reset_credit: got %0d want 0", credit); end
    n_cmp++; if (credit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", credit_valid); end
    n_cmp++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL reset_reject: got %b want 0", coin_reject); end
    n_cmp++; if (refund_valid !== 1'b0 || refund_amt !== 5'd0) begin
      n_fail++; $display("FAIL reset_refund: got %b/%0d want 0/0", refund_valid, refund_amt); end
  endtask

  task automatic test_max_offer();
    do_reset();
    step(1, 2'b01, 0, 0);
    n_cmp++; if (credit !== 5'd5) begin n_fail++; $display("FAIL max_first_coin: got %0d want 5", credit); end
    step(1, 2'b10, 0, 0);
    n_cmp++; if (credit !== 5'd15 || credit_valid !== 1'b1) begin
      n_fail++; $display("FAIL max_offer: got %0d/%b want 15/1", credit, credit_valid); end
    step(1, 2'b01, 0, 0);
    n_cmp++; if (coin_reject !== 1'b1 || credit !== 5'd15 || credit_valid !== 1'b1) begin
      n_fail++; $display("FAIL offer_coin_reject: got rej %b credit %0d valid %b want 1/15/1", coin_reject, credit, credit_valid); end
    step(0, 2'b00, 0, 1);
    n_cmp++; if (credit !== 5'd0 || credit_valid !== 1'b0) begin
      n_fail++; $display("FAIL max_ack: got %0d/%b want 0/0", credit, credit_valid); end
  endtask

  task automatic test_settle();
    int cnt;
    do_reset();
    step(1, 2'b10, 0, 0);
    n_cmp++; if (credit !== 5'd10 || credit_valid !== 1'b0) begin
      n_fail++; $display("FAIL settle_update: got %0d/%b want 10/0", credit, credit_valid); end
    cnt = 0;
    while (credit_valid !== 1'b1 && cnt < 40) begin idle(); cnt++; end
    n_cmp++; if (cnt != S) begin n_fail++; $display("FAIL settle_latency: got %0d want %0d", cnt, S); end
    repeat (5) idle();
    n_cmp++; if (credit !== 5'd10 || credit_valid !== 1'b1) begin
      n_fail++; $display("FAIL settle_hold: got %0d/%b want 10/1", credit, credit_valid); end
    step(0, 2'b00, 0, 1);
    n_cmp++; if (credit !== 5'd0 || credit_valid !== 1'b0) begin
      n_fail++; $display("FAIL settle_ack: got %0d/%b want 0/0", credit, credit_valid); end
  endtask

  task automatic test_overlimit();
    do_reset();
    step(1, 2'b01, 0, 0);
    step(1, 2'b01, 0, 0);
    step(1, 2'b10, 0, 0);
    n_cmp++; if (coin_reject !== 1'b1 || credit !== 5'd10) begin
      n_fail++; $display("FAIL overlimit_reject: got rej %b credit %0d want 1/10", coin_reject, credit); end
    step(1, 2'b01, 0, 0);
    n_cmp++; if (coin_reject !== 1'b0 || credit !== 5'd15 || credit_valid !== 1'b1) begin
      n_fail++; $display("FAIL overlimit_fill: got rej %b credit %0d valid %b want 0/15/1", coin_reject, credit, credit_valid); end
    step(0, 2'b00, 0, 1);
  endtask

  task automatic test_cancel_with_coin();
    do_reset();
    step(1, 2'b10, 0, 0);
    step(1, 2'b01, 1, 0);
    n_cmp++; if (coin_reject !== 1'b1 || refund_valid !== 1'b1 || refund_amt !== 5'd10) begin
      n_fail++; $display("FAIL cancel_coin: got rej %b refund %b amt %0d want 1/1/10", coin_reject, refund_valid, refund_amt); end
    idle();
    n_cmp++; if (credit !== 5'd0 || refund_valid !== 1'b0 || refund_amt !== 5'd0) begin
      n_fail++; $display("FAIL cancel_clear: got credit %0d refund %b amt %0d want 0/0/0", credit, refund_valid, refund_amt); end
  endtask

  task automatic test_ack_beats_cancel();
    do_reset();
    step(1, 2'b01, 0, 0);
    step(1, 2'b10, 0, 0);
    step(0, 2'b00, 1, 1);
    n_cmp++; if (refund_valid !== 1'b0 || credit !== 5'd0 || credit_valid !== 1'b0) begin
      n_fail++; $display("FAIL ack_cancel: got refund %b credit %0d valid %b want 0/0/0", refund_valid, credit, credit_valid); end
    idle();
    n_cmp++; if (refund_valid !== 1'b0) begin n_fail++; $display("FAIL ack_cancel_late: got refund %b want 0", refund_valid); end
    step(1, 2'b11, 0, 0);
    n_cmp++; if (coin_reject !== 1'b1 || credit !== 5'd0) begin
      n_fail++; $display("FAIL bad_coin: got rej %b credit %0d want 1/0", coin_reject, credit); end
    step(0, 2'b00, 1, 0);
    n_cmp++; if (refund_valid !== 1'b0) begin n_fail++; $display("FAIL idle_cancel: got refund %b want 0", refund_valid); end
    step(1, 2'b01, 0, 0);
    n_cmp++; if (credit !== 5'd5 || coin_reject !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_bad: got credit %0d rej %b want 5/0", credit, coin_reject); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 2'b01, 0, 0);
    n_cmp++; if (credit !== 5'd5) begin n_fail++; $display("FAIL areset_pre: got %0d want 5", credit); end
    #3 rst = 1;
    #1;
    n_cmp++; if (credit !== 5'd0 || credit_valid !== 1'b0 || refund_valid !== 1'b0) begin
      n_fail++; $display("FAIL areset_now: got credit %0d valid %b refund %b want 0/0/0", credit, credit_valid, refund_valid); end
    @(posedge clk); #1;
    n_cmp++; if (refund_valid !== 1'b0 || refund_amt !== 5'd0) begin
      n_fail++; $display("FAIL areset_refund: got %b/%0d want 0/0", refund_valid, refund_amt); end
    rst = 0;
    model_reset();
  endtask

  task automatic test_offer_timeout();
    bit bad;
    do_reset();
    step(1, 2'b01, 0, 0);
    step(1, 2'b10, 0, 0);
    bad = 0;
    for (int i = 0; i < 16 * S - 1; i++) begin
      idle();
      if (refund_valid !== 1'b0 || credit_valid !== 1'b1) bad = 1;
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL offer_wait: got early exit from offer, want offer held"); end
    idle();
`ifdef COIN_AUTO_REFUND_EN
    n_cmp++; if (refund_valid !== 1'b1 || refund_amt !== 5'd15 || credit_valid !== 1'b0) begin
      n_fail++; $display("FAIL watchdog_refund: got %b/%0d valid %b want 1/15/0", refund_valid, refund_amt, credit_valid); end
    idle();
    n_cmp++; if (credit !== 5'd0 || refund_valid !== 1'b0) begin
      n_fail++; $display("FAIL watchdog_clear: got %0d/%b want 0/0", credit, refund_valid); end
`else
    repeat (40) idle();
    n_cmp++; if (refund_valid !== 1'b0 || credit_valid !== 1'b1 || credit !== 5'd15) begin
      n_fail++; $display("FAIL offer_forever: got refund %b valid %b credit %0d want 0/1/15", refund_valid, credit_valid, credit); end
    step(0, 2'b00, 0, 1);
`endif
  endtask

  task automatic test_random();
    bit cv, cn, ack;
    bit [1:0] ct;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cv  = ($urandom_range(0, 1) == 1);
      ct  = 2'($urandom_range(0, 3));
      cn  = ($urandom_range(0, 11) == 0);
      ack = ($urandom_range(0, 5) == 0);
      step(cv, ct, cn, ack);
      n_cmp++; if (credit !== W'(m_credit)) begin n_fail++; $display("FAIL rnd_credit cyc %0d: got %0d want %0d", i, credit, m_credit); end
      n_cmp++; if (credit_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d: got %b want %b", i, credit_valid, m_valid); end
      n_cmp++; if (coin_reject !== m_reject) begin n_fail++; $display("FAIL rnd_reject cyc %0d: got %b want %b", i, coin_reject, m_reject); end
      n_cmp++; if (refund_valid !== m_refund) begin n_fail++; $display("FAIL rnd_refund cyc %0d: got %b want %b", i, refund_valid, m_refund); end
      n_cmp++; if (refund_amt !== W'(m_refund_amt)) begin n_fail++; $display("FAIL rnd_amt cyc %0d: got %0d want %0d", i, refund_amt, m_refund_amt); end
    end
  endtask

  initial begin
    rst = 1; coin_valid = 0; coin_type = 2'b00; cancel = 0; vend_ack = 0;
    model_reset();
    test_reset();
    test_max_offer();
    test_settle();
    test_overlimit();
    test_cancel_with_coin();
    test_ack_beats_cancel();
    test_async_reset();
    test_offer_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
